// File: rtl/conf_stream_loader_pkg.sv
// Shared types and width helpers for the configuration stream loader.
package conf_stream_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        NEXT  = 2'd3
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2w(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    function automatic int conf_bytes(input int conf_bits, input int byte_bits);
        return conf_bits / byte_bits;
    endfunction

endpackage

// File: rtl/conf_stream_loader_byte_pending_buffer.sv
// One-deep holding register for a byte that arrives while another is shifting.
module byte_pending_buffer #(
    parameter int BYTE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 wr,
    input  logic [BYTE_BITS-1:0] wr_data,
    input  logic                 rd,
    output logic                 full,
    output logic [BYTE_BITS-1:0] data,
    output logic                 overrun
);

    logic                 full_reg;
    logic [BYTE_BITS-1:0] data_reg;
    logic                 overrun_reg;
    logic                 drop;

    // A write in the same cycle as a read refills the slot instead of overflowing.
    assign drop = wr && full_reg && !rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg    <= 1'b0;
            data_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr && !drop) begin
                data_reg <= wr_data;
                full_reg <= 1'b1;
            end else if (rd) begin
                full_reg <= 1'b0;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (clear) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign full    = full_reg;
    assign data    = data_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/conf_stream_loader.sv
// Shifts received UART bytes MSB-first into the ch_conf shift register,
// generating its shift clock and tracking frame progress.
module conf_stream_loader
    import conf_stream_loader_pkg::*;
#(
    parameter int CONF_BITS = 80,
    parameter int BYTE_BITS = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BYTE_BITS-1:0] i_data,
    input  logic                 i_avail,
    input  logic                 i_clear,
    output logic                 o_sh_clk,
    output logic                 o_ser,
    output logic                 o_busy,
    output logic [clog2w(conf_bytes(CONF_BITS, BYTE_BITS) + 1)-1:0] o_byte_cnt,
    output logic                 o_done,
    output logic                 o_conf_valid,
    output logic                 o_overrun
);

    localparam int CONF_BYTES = conf_bytes(CONF_BITS, BYTE_BITS);
    localparam int CNT_W      = clog2w(CONF_BYTES + 1);
    localparam int BIT_W      = clog2w(BYTE_BITS);
    localparam int IDLE_W     = clog2w(TIMEOUT + 1);

    state_t               state_reg, state_next;
    logic [BYTE_BITS-1:0] shift_byte_reg;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic [CNT_W-1:0]     byte_cnt_reg;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 done_reg;
    logic                 conf_valid_reg;
    logic                 avail_hist_reg;

    logic                 avail_edge;
    logic                 load;
    logic [BYTE_BITS-1:0] load_data;
    logic                 consume;
    logic                 pend_wr;
    logic                 pend_full;
    logic [BYTE_BITS-1:0] pend_data;
    logic                 frame_end;
    logic                 timeout_hit;

    assign avail_edge = i_avail && !avail_hist_reg;
    assign cnt_inc    = byte_cnt_reg + 1'b1;
    assign frame_end  = (state_reg == NEXT) && (cnt_inc == CNT_W'(CONF_BYTES));

    // An idle controller with nothing pending takes the new byte directly.
    assign pend_wr = avail_edge && !((state_reg == IDLE) && !pend_full);

    byte_pending_buffer #(
        .BYTE_BITS (BYTE_BITS)
    ) u_pending (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (i_clear),
        .wr      (pend_wr),
        .wr_data (i_data),
        .rd      (consume),
        .full    (pend_full),
        .data    (pend_data),
        .overrun (o_overrun)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        load_data  = i_data;
        consume    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pend_full) begin
                    state_next = SETUP;
                    load       = 1'b1;
                    load_data  = pend_data;
                    consume    = 1'b1;
                end else if (avail_edge) begin
                    state_next = SETUP;
                    load       = 1'b1;
                end
            end
            SETUP: state_next = PULSE;
            PULSE: state_next = (bit_idx_reg == '0) ? NEXT : SETUP;
            NEXT: begin
                if (pend_full) begin
                    state_next = SETUP;
                    load       = 1'b1;
                    load_data  = pend_data;
                    consume    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            shift_byte_reg <= '0;
            bit_idx_reg    <= '0;
            byte_cnt_reg   <= '0;
            done_reg       <= 1'b0;
            conf_valid_reg <= 1'b0;
            avail_hist_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            avail_hist_reg <= i_avail;
            done_reg       <= frame_end;
            if (load) begin
                shift_byte_reg <= load_data;
                bit_idx_reg    <= BIT_W'(BYTE_BITS - 1);
            end else if ((state_reg == PULSE) && (bit_idx_reg != '0)) begin
                bit_idx_reg <= bit_idx_reg - 1'b1;
            end
            // Clear overrides a frame completing in the same cycle.
            if (i_clear) begin
                byte_cnt_reg <= '0;
            end else if (state_reg == NEXT) begin
                byte_cnt_reg <= frame_end ? '0 : cnt_inc;
            end else if (timeout_hit) begin
                byte_cnt_reg <= '0;
            end
            if (i_clear) begin
                conf_valid_reg <= 1'b0;
            end else if (frame_end) begin
                conf_valid_reg <= 1'b1;
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            logic [IDLE_W-1:0] idle_cnt_reg;
            logic              counting;

            assign counting    = (state_reg == IDLE) && (byte_cnt_reg != '0) && !avail_edge;
            assign timeout_hit = counting && (idle_cnt_reg == IDLE_W'(TIMEOUT - 1));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    idle_cnt_reg <= '0;
                end else if (!counting || timeout_hit) begin
                    idle_cnt_reg <= '0;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // The serial bit only moves on entering SETUP, while the shift clock is low.
    assign o_sh_clk     = (state_reg == PULSE);
    assign o_ser        = shift_byte_reg[bit_idx_reg];
    assign o_busy       = (state_reg != IDLE);
    assign o_byte_cnt   = byte_cnt_reg;
    assign o_done       = done_reg;
    assign o_conf_valid = conf_valid_reg;

endmodule

// File: tb/tb_conf_stream_loader.sv
// Directed bench for conf_stream_loader with a behavioural model of the ch_conf register.
module tb_conf_stream_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       avail = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data = 8'h00;
    logic       sh_clk, ser, busy, done, conf_valid, overrun;
    logic [3:0] byte_cnt;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int busy_cycles = 0;
    int busy_runs = 0;
    int done_cnt = 0;
    logic prev_busy = 1'b0;
    logic [79:0] model_reg = '0;

    always #5 clk = ~clk;

    conf_stream_loader #(
        .CONF_BITS (80),
        .BYTE_BITS (8),
        .TIMEOUT   (64)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_avail      (avail),
        .i_clear      (clear),
        .o_sh_clk     (sh_clk),
        .o_ser        (ser),
        .o_busy       (busy),
        .o_byte_cnt   (byte_cnt),
        .o_done       (done),
        .o_conf_valid (conf_valid),
        .o_overrun    (overrun)
    );

    // Model of the ch_conf shift register clocked by the generated shift clock.
    always @(posedge sh_clk) begin
        model_reg = {model_reg[78:0], ser};
        pulse_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_cycles++;
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_runs++;
        prev_busy = busy;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_avail(input logic [7:0] b);
        data  = b;
        avail = 1'b1;
        step();
        avail = 1'b0;
    endtask

    task automatic clear_counters();
        pulse_cnt   = 0;
        busy_cycles = 0;
        busy_runs   = 0;
        done_cnt    = 0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        avail = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sh_clk, ser, busy, byte_cnt, done, conf_valid, overrun} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0000000000",
                     {sh_clk, ser, busy, byte_cnt, done, conf_valid, overrun});
        end
        rst = 1'b0;
        run(5);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_avail_high_ignored: busy got %b required 0", busy);
        end
        avail = 1'b0;
        run(2);
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        clear_counters();
        data  = 8'hB4;
        avail = 1'b1;
        step();
        checks++;
        if (sh_clk !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_setup: sh_clk/busy got %b%b required 01", sh_clk, busy);
        end
        avail = 1'b0;
        step();
        checks++;
        if (sh_clk !== 1'b1) begin
            failures++;
            $display("FAIL single_first_pulse: sh_clk got %b required 1", sh_clk);
        end
        run(25);
        checks++;
        if (pulse_cnt != 8) begin
            failures++;
            $display("FAIL single_pulses: got %0d required 8", pulse_cnt);
        end
        checks++;
        if (model_reg[7:0] !== 8'hB4) begin
            failures++;
            $display("FAIL single_bits: got %h required b4", model_reg[7:0]);
        end
        checks++;
        if (busy_cycles != 17) begin
            failures++;
            $display("FAIL single_busy_cycles: got %0d required 17", busy_cycles);
        end
        checks++;
        if (byte_cnt !== 4'd1) begin
            failures++;
            $display("FAIL single_byte_cnt: got %0d required 1", byte_cnt);
        end
        $display("test_single_byte pulses=%0d busy=%0d", pulse_cnt, busy_cycles);
    endtask

    task automatic test_ten_bytes();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (byte_cnt !== 4'd0 || conf_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_state: cnt/valid got %0d/%b required 0/0", byte_cnt, conf_valid);
        end
        clear_counters();
        for (int i = 1; i <= 10; i++) begin
            pulse_avail(8'(i));
            run(29);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL frame_done_pulses: got %0d required 1", done_cnt);
        end
        checks++;
        if (conf_valid !== 1'b1) begin
            failures++;
            $display("FAIL frame_conf_valid: got %b required 1", conf_valid);
        end
        checks++;
        if (byte_cnt !== 4'd0) begin
            failures++;
            $display("FAIL frame_byte_cnt: got %0d required 0", byte_cnt);
        end
        checks++;
        if (model_reg !== 80'h0102030405060708090A) begin
            failures++;
            $display("FAIL frame_register: got %h required 0102030405060708090a", model_reg);
        end
        $display("test_ten_bytes reg=%h", model_reg);
    endtask

    task automatic test_back_to_back();
        clear_counters();
        pulse_avail(8'hA5);
        run(3);
        pulse_avail(8'h3C);
        run(45);
        checks++;
        if (busy_cycles != 34 || busy_runs != 1) begin
            failures++;
            $display("FAIL b2b_busy: cycles/runs got %0d/%0d required 34/1", busy_cycles, busy_runs);
        end
        checks++;
        if (model_reg[15:0] !== 16'hA53C) begin
            failures++;
            $display("FAIL b2b_bits: got %h required a53c", model_reg[15:0]);
        end
        checks++;
        if (byte_cnt !== 4'd2 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_cnt_overrun: got %0d/%b required 2/0", byte_cnt, overrun);
        end
        checks++;
        if (conf_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_conf_valid_kept: got %b required 1", conf_valid);
        end
        $display("test_back_to_back busy=%0d runs=%0d", busy_cycles, busy_runs);
    endtask

    task automatic test_overrun();
        clear = 1'b1;
        step();
        clear = 1'b0;
        clear_counters();
        pulse_avail(8'h11);
        run(2);
        pulse_avail(8'h22);
        run(2);
        pulse_avail(8'h33);
        run(50);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        checks++;
        if (byte_cnt !== 4'd2 || model_reg[15:0] !== 16'h1122) begin
            failures++;
            $display("FAIL overrun_kept_bytes: cnt/bits got %0d/%h required 2/1122", byte_cnt, model_reg[15:0]);
        end
        run(30);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (overrun !== 1'b0 || byte_cnt !== 4'd0) begin
            failures++;
            $display("FAIL overrun_clear: ovr/cnt got %b/%0d required 0/0", overrun, byte_cnt);
        end
        $display("test_overrun done");
    endtask

    task automatic test_timeout();
        clear_counters();
        for (int i = 0; i < 3; i++) begin
            pulse_avail(8'hC0 + 8'(i));
            if (i < 2) run(19);
        end
        run(17);
        checks++;
        if (byte_cnt !== 4'd3) begin
            failures++;
            $display("FAIL timeout_three_bytes: got %0d required 3", byte_cnt);
        end
        run(63);
        checks++;
        if (byte_cnt !== 4'd3) begin
            failures++;
            $display("FAIL timeout_before_limit: got %0d required 3", byte_cnt);
        end
        step();
        checks++;
        if (byte_cnt !== 4'd0) begin
            failures++;
            $display("FAIL timeout_at_limit: got %0d required 0", byte_cnt);
        end
        for (int i = 1; i <= 10; i++) begin
            pulse_avail(8'h10 + 8'(i));
            run(29);
        end
        checks++;
        if (done_cnt != 1 || conf_valid !== 1'b1 || byte_cnt !== 4'd0) begin
            failures++;
            $display("FAIL timeout_next_frame: done/valid/cnt got %0d/%b/%0d required 1/1/0",
                     done_cnt, conf_valid, byte_cnt);
        end
        checks++;
        if (model_reg !== 80'h1112131415161718191A) begin
            failures++;
            $display("FAIL timeout_frame_register: got %h required 1112131415161718191a", model_reg);
        end
        $display("test_timeout reg=%h", model_reg);
    endtask

    task automatic test_clear_vs_done();
        clear_counters();
        for (int i = 1; i <= 9; i++) begin
            pulse_avail(8'h20 + 8'(i));
            run(29);
        end
        pulse_avail(8'h2A);
        run(15);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (done !== 1'b1 || done_cnt != 1) begin
            failures++;
            $display("FAIL clear_vs_done_pulse: done/count got %b/%0d required 1/1", done, done_cnt);
        end
        checks++;
        if (conf_valid !== 1'b0 || byte_cnt !== 4'd0) begin
            failures++;
            $display("FAIL clear_vs_done_valid: valid/cnt got %b/%0d required 0/0", conf_valid, byte_cnt);
        end
        run(3);
        $display("test_clear_vs_done done");
    endtask

    task automatic test_reset_mid_shift();
        clear_counters();
        pulse_avail(8'h81);
        run(25);
        pulse_avail(8'hFF);
        run(9);
        checks++;
        if (sh_clk !== 1'b1 || byte_cnt !== 4'd1) begin
            failures++;
            $display("FAIL mid_shift_precondition: sh_clk/cnt got %b/%0d required 1/1", sh_clk, byte_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sh_clk !== 1'b0 || busy !== 1'b0 || byte_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_shift_reset: sh_clk/busy/cnt got %b/%b/%0d required 0/0/0",
                     sh_clk, busy, byte_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(2);
        clear_counters();
        pulse_avail(8'h5A);
        run(25);
        checks++;
        if (pulse_cnt != 8 || model_reg[7:0] !== 8'h5A) begin
            failures++;
            $display("FAIL after_reset_byte: pulses/bits got %0d/%h required 8/5a", pulse_cnt, model_reg[7:0]);
        end
        checks++;
        if (byte_cnt !== 4'd1 || busy_cycles != 17) begin
            failures++;
            $display("FAIL after_reset_cnt: cnt/busy got %0d/%0d required 1/17", byte_cnt, busy_cycles);
        end
        $display("test_reset_mid_shift done");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_ten_bytes();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_clear_vs_done();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conf_stream_loader.md
Name: conf_stream_loader

Overview:
- Sequences received UART bytes into the channel-configuration shift register, one bit per generated shift-clock pulse.
- Replaces the hand-built edge detector, RS flip-flop and half-cycle counter with a single controller.
- Sits between uart_rx (data/avail) and the CONF_BITS-wide ch_conf shift_register.
- Tracks frame progress and flags a completed configuration, overruns and inter-byte timeouts.

Parameters:
- CONF_BITS, 80, length of the config shift register; must be a multiple of BYTE_BITS.
- BYTE_BITS, 8, bits per received byte.
- TIMEOUT, 4096, idle clock cycles after which a partial frame is discarded; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  BYTE_BITS  received byte from uart_rx; valid when i_avail rises.
- i_avail  in  1  uart_rx avail level; a 0->1 transition marks a new byte.
- i_clear  in  1  synchronous pulse; clears o_conf_valid, o_overrun and the byte count.
- o_sh_clk  out  1  shift clock to ch_conf; the register shifts on its rising edge.
- o_ser  out  1  serial data to ch_conf ser_in.
- o_busy  out  1  high while a byte is being shifted.
- o_byte_cnt  out  clog2(CONF_BITS/BYTE_BITS+1)  bytes shifted in the current frame.
- o_done  out  1  one-cycle pulse when the last byte of a frame finishes shifting.
- o_conf_valid  out  1  level, set with o_done.
- o_overrun  out  1  sticky; set when a byte is lost.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Pending buffer empty.
  - Edge-detect history register = 1, so an avail already high at reset release is not taken as a byte.
- Byte capture:
  - Registered rising-edge detect on i_avail.
  - On an edge, i_data is latched the same cycle.
  - In IDLE, the byte goes straight to the shift register.
  - Otherwise it goes to a one-deep pending buffer.
  - If pending is already full, the byte is dropped and o_overrun is set.
- FSM states: IDLE, SETUP, PULSE, NEXT.
  - IDLE -> SETUP when a byte is available (new edge or pending). Load the shift byte and set bit_idx = BYTE_BITS-1.
  - SETUP: o_sh_clk=0; o_ser = shift_byte[bit_idx]. Bits go MSB first. -> PULSE.
  - PULSE: o_sh_clk=1; o_ser held. If bit_idx==0 -> NEXT, else decrement bit_idx and -> SETUP.
  - NEXT: o_sh_clk=0; o_byte_cnt += 1.
    - If the new count == CONF_BITS/BYTE_BITS: pulse o_done, set o_conf_valid, reset o_byte_cnt to 0.
    - If pending is full -> SETUP with the pending byte and clear pending; else -> IDLE.
- Timing:
  - o_ser changes only while o_sh_clk is low.
  - One byte = 2*BYTE_BITS+1 cycles from IDLE exit to NEXT completion (17 for 8 bits).
  - First o_sh_clk rising edge occurs 2 cycles after the avail edge is detected.
- o_busy: high in SETUP, PULSE and NEXT.
- Timeout:
  - The idle counter runs while in IDLE with 0 < o_byte_cnt < max.
  - It clears on any avail edge.
  - On reaching TIMEOUT: o_byte_cnt is set to 0. o_conf_valid is unchanged, and the register contents are not rewritten.
- Simultaneous events:
  - i_clear in the same cycle as NEXT completing a frame: i_clear wins; o_done still pulses, o_conf_valid stays 0.
  - Avail edge in the same cycle pending is consumed: the new byte goes into pending, with no overrun.
  - A new frame's first byte does not clear o_conf_valid.
- Reset mid-shift:
  - All state is dropped immediately.
  - o_sh_clk goes to 0 asynchronously.
  - The partially shifted register content is not repaired.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (2-bit).
  - The CONF_BYTES = CONF_BITS/BYTE_BITS derivation.
  - The clog2 width function.
- One natural sub-module: a byte_pending_buffer (one-deep holding register with full flag and overrun output).
- Edge detection stays inline. Existing rising_edge_detector is not used because its reset behaviour does not match.

Test Plan:
- Single byte 0xB4 in IDLE:
  - 8 o_sh_clk pulses.
  - o_ser sampled at each rising edge = 1,0,1,1,0,1,0,0.
  - o_byte_cnt 0->1; o_busy high for 17 cycles.
- 10 bytes 0x01..0x0A spaced 30 cycles:
  - o_done is a single pulse after the 10th byte.
  - o_conf_valid=1; o_byte_cnt=0.
  - Model 80-bit register equals 0x0102030405060708090A.
- Two avail edges 4 cycles apart:
  - Second byte is held in pending and shifted back-to-back (SETUP immediately after NEXT).
  - o_overrun=0.
- Three avail edges within 10 cycles:
  - Third byte dropped; o_overrun=1 and stays set until i_clear.
  - o_byte_cnt ends at 2.
- Three bytes, then idle TIMEOUT=64 cycles:
  - o_byte_cnt returns to 0 at cycle 64.
  - The next 10 bytes complete a frame normally.
- i_rst asserted during PULSE of bit 3:
  - o_sh_clk=0, o_busy=0, o_byte_cnt=0 immediately.
  - After release, a new byte shifts all 8 bits.
